// File: rtl/async_hs_pkg.sv
// ============================================================================
// Module      : async_hs_pkg
// Description : Shared types for the 4-phase req/ack client/server pair.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package async_hs_pkg;

    localparam int HS_DW = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        REQ_HI = 3'd2,
        REQ_LO = 3'd3,
        ABORT  = 3'd4
    } client_state_t;

endpackage

`default_nettype wire

// File: rtl/hs_sync.sv
// ============================================================================
// Module      : hs_sync
// Description : N-flop single-bit synchroniser with asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hs_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/async_client.sv
// ============================================================================
// Module      : async_client
// Description : Initiator end of a 4-phase req/ack handshake with watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module async_client
    import async_hs_pkg::*;
#(
    parameter int DW           = HS_DW,
    parameter int SYNC_STAGES  = 2,
    parameter int SETUP_CYCLES = 2,
    parameter int TIMEOUT      = 1024
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [DW-1:0] cmd_data,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic          req,
    input  logic          ack,
    output logic [DW-1:0] data_out,
    input  logic [DW-1:0] data_in,
    output logic          busy,
    output logic          timeout_err,
    input  logic          err_clr
);

    localparam int CNT_W_TO = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam int CNT_W_SU = $clog2(SETUP_CYCLES + 1);
    localparam int CNT_W    = (CNT_W_TO > CNT_W_SU) ? CNT_W_TO : CNT_W_SU;

    localparam logic [CNT_W-1:0] CNT_SETUP = CNT_W'(SETUP_CYCLES);
    localparam logic [CNT_W-1:0] CNT_EXP   = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    client_state_t state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             req_q;
    logic [DW-1:0]    data_out_q;
    logic [DW-1:0]    rsp_data_q;
    logic             rsp_valid_q;
    logic             timeout_err_q;
    logic             ack_s;
    logic             wd_expired;

    hs_sync #(
        .STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk (clk),
        .rst (rst),
        .d_i (ack),
        .q_o (ack_s)
    );

    // Watchdog disabled entirely when TIMEOUT is zero.
    assign wd_expired = (TIMEOUT != 0) && (cnt_q == CNT_EXP);

    assign cmd_ready   = (state_q == IDLE) && !rsp_valid_q && !ack_s;
    assign busy        = (state_q != IDLE);
    assign req         = req_q;
    assign data_out    = data_out_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign timeout_err = timeout_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            req_q         <= 1'b0;
            data_out_q    <= '0;
            rsp_data_q    <= '0;
            rsp_valid_q   <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            // Clears come first so a same-cycle set below takes precedence.
            if (rsp_valid_q && rsp_ready) rsp_valid_q <= 1'b0;
            if (err_clr) timeout_err_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        data_out_q <= cmd_data;
                        cnt_q      <= '0;
                        state_q    <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt_q == CNT_SETUP) begin
                        req_q   <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= REQ_HI;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                REQ_HI: begin
                    if (ack_s) begin
                        rsp_data_q  <= data_in;
                        rsp_valid_q <= 1'b1;
                        req_q       <= 1'b0;
                        cnt_q       <= '0;
                        state_q     <= REQ_LO;
                    end else if (wd_expired) begin
                        timeout_err_q <= 1'b1;
                        req_q         <= 1'b0;
                        state_q       <= ABORT;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                REQ_LO: begin
                    if (!ack_s) begin
                        state_q <= IDLE;
                    end else if (wd_expired) begin
                        timeout_err_q <= 1'b1;
                        state_q       <= ABORT;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ABORT: begin
                    if (!ack_s) state_q <= IDLE;
                end
                default: begin
                    req_q   <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_async_client.sv
// ============================================================================
// Module      : tb_async_client
// Description : Self-checking bench for async_client against a timestamp model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_async_client;

    localparam int SYNC  = 2;
    localparam int SETUP = 2;
    localparam int TO    = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_data = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        req;
    logic        ack = 1'b0;
    logic [31:0] data_out;
    logic [31:0] data_in = '0;
    logic        busy;
    logic        timeout_err;
    logic        err_clr = 1'b0;

    int n_vec = 0;
    int n_mis = 0;
    bit cmp_en = 1'b0;
    bit mon_en = 1'b0;

    async_client #(
        .DW           (32),
        .SYNC_STAGES  (SYNC),
        .SETUP_CYCLES (SETUP),
        .TIMEOUT      (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_data    (cmd_data),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .req         (req),
        .ack         (ack),
        .data_out    (data_out),
        .data_in     (data_in),
        .busy        (busy),
        .timeout_err (timeout_err),
        .err_clr     (err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: time is measured in clock edges since reset. The synchronised
    // ack seen at edge e is the raw ack sampled at edge e-SYNC; setup and
    // watchdog are tracked as absolute edge deadlines.
    int          m_e;
    bit          a_hist [256];
    int          m_phase;   // 0 idle, 1 setup, 2 req high, 3 req low, 4 abort
    int          m_rise_at;
    int          m_deadline;
    logic        m_req, m_rsp_valid, m_err;
    logic [31:0] m_dout, m_rdata;

    function automatic bit ack_s_at(input int e);
        return (e > SYNC) ? a_hist[(e - SYNC) % 256] : 1'b0;
    endfunction

    function automatic bit m_cmd_ready();
        return (m_phase == 0) && !m_rsp_valid && !ack_s_at(m_e + 1);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_e <= 0; m_phase <= 0; m_rise_at <= 0; m_deadline <= 0;
            m_req <= 1'b0; m_rsp_valid <= 1'b0; m_err <= 1'b0;
            m_dout <= '0; m_rdata <= '0;
        end else begin
            m_e <= m_e + 1;
            a_hist[(m_e + 1) % 256] <= ack;
            if (m_rsp_valid && rsp_ready) m_rsp_valid <= 1'b0;
            if (err_clr) m_err <= 1'b0;
            case (m_phase)
                0: if (cmd_valid && m_cmd_ready()) begin
                    m_dout <= cmd_data; m_rise_at <= m_e + 1 + SETUP + 1; m_phase <= 1;
                end
                1: if (m_e + 1 == m_rise_at) begin
                    m_req <= 1'b1; m_deadline <= m_e + 1 + TO; m_phase <= 2;
                end
                2: if (ack_s_at(m_e + 1)) begin
                    m_rdata <= data_in; m_rsp_valid <= 1'b1; m_req <= 1'b0;
                    m_deadline <= m_e + 1 + TO; m_phase <= 3;
                end else if (m_e + 1 == m_deadline) begin
                    m_err <= 1'b1; m_req <= 1'b0; m_phase <= 4;
                end
                3: if (!ack_s_at(m_e + 1)) m_phase <= 0;
                   else if (m_e + 1 == m_deadline) begin m_err <= 1'b1; m_phase <= 4; end
                default: if (!ack_s_at(m_e + 1)) m_phase <= 0;
            endcase
        end
    end

    logic prev_req = 1'b0;
    always @(negedge clk) begin
        if (!rst && cmp_en) begin
            chk("m_req",         req,         m_req);
            chk("m_data_out",    data_out,    m_dout);
            chk("m_rsp_valid",   rsp_valid,   m_rsp_valid);
            chk("m_rsp_data",    rsp_data,    m_rdata);
            chk("m_timeout_err", timeout_err, m_err);
            chk("m_busy",        busy,        m_phase != 0);
            chk("m_cmd_ready",   cmd_ready,   m_cmd_ready());
            if (mon_en && req !== prev_req) begin
                if (req) chk("4ph_rise_ack_low",  ack, 1'b0);
                else     chk("4ph_fall_ack_high", ack, 1'b1);
            end
        end
        prev_req = req;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_sig(input int which, input logic val, input int maxc, input string name);
        bit hit = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            if (((which == 0) ? req : cmd_ready) === val) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk(name, hit, 1'b1);
    endtask

    task automatic issue(input logic [31:0] c);
        wait_sig(1, 1'b1, 20, "wait_cmd_ready");
        cmd_valid = 1'b1; cmd_data = c;
        tick(1);
        cmd_valid = 1'b0;
    endtask

    task automatic do_txn(input logic [31:0] c, input logic [31:0] r, input int dly);
        issue(c);
        wait_sig(0, 1'b1, 10, "wait_req_rise");
        tick(dly);
        ack = 1'b1; data_in = r;
        wait_sig(0, 1'b0, 15, "wait_req_fall");
        chk("txn_rsp_valid", rsp_valid, 1'b1);
        chk("txn_rsp_data",  rsp_data,  r);
        tick($urandom_range(1, 4));
        ack = 1'b0; data_in = $urandom;
        rsp_ready = 1'b1;
        tick(1);
        rsp_ready = 1'b0;
    endtask

    initial begin
        // Reset state
        tick(3);
        chk("rst_req", req, 1'b0);
        chk("rst_data_out", data_out, 32'h0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_timeout_err", timeout_err, 1'b0);
        chk("rst_busy", busy, 1'b0);
        rst = 1'b0;
        cmp_en = 1'b1;
        tick(1);
        chk("idle_cmd_ready", cmd_ready, 1'b1);

        // 1: command, req at edge 3, ack after 5 cycles, response 3 edges later
        cmd_valid = 1'b1; cmd_data = 32'hDEAD_0001;
        tick(1);
        cmd_valid = 1'b0;
        tick(2);
        chk("t1_req_edge2", req, 1'b0);
        tick(1);
        chk("t1_req_edge3", req, 1'b1);
        chk("t1_data_out", data_out, 32'hDEAD_0001);
        tick(4);
        ack = 1'b1; data_in = 32'h0000_0042;
        tick(2);
        chk("t1_rsp_valid_early", rsp_valid, 1'b0);
        tick(1);
        chk("t1_rsp_valid", rsp_valid, 1'b1);
        chk("t1_rsp_data", rsp_data, 32'h0000_0042);
        chk("t1_req_fall", req, 1'b0);
        ack = 1'b0;

        // 2: response held while consumer stalls
        for (int i = 0; i < 20; i++) begin
            tick(1);
            chk("t2_rsp_hold", rsp_valid, 1'b1);
            chk("t2_cmd_ready_low", cmd_ready, 1'b0);
        end
        chk("t2_rsp_data_hold", rsp_data, 32'h0000_0042);
        rsp_ready = 1'b1;
        tick(1);
        rsp_ready = 1'b0;
        chk("t2_rsp_cleared", rsp_valid, 1'b0);
        chk("t2_cmd_ready", cmd_ready, 1'b1);

        // 3: server never acks -> watchdog at cycle 16 of REQ_HI
        issue(32'h1111_0003);
        wait_sig(0, 1'b1, 10, "t3_wait_req");
        tick(TO - 1);
        chk("t3_err_before", timeout_err, 1'b0);
        tick(1);
        chk("t3_err_set", timeout_err, 1'b1);
        chk("t3_req_low", req, 1'b0);
        tick(1);
        chk("t3_idle", busy, 1'b0);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("t3_err_clr", timeout_err, 1'b0);

        // 4: ack stuck high after req falls -> ABORT until ack_s drops
        issue(32'h2222_0004);
        wait_sig(0, 1'b1, 10, "t4_wait_req");
        ack = 1'b1; data_in = 32'hCAFE_0004;
        wait_sig(0, 1'b0, 10, "t4_wait_req_fall");
        tick(30);
        chk("t4_err", timeout_err, 1'b1);
        chk("t4_busy", busy, 1'b1);
        chk("t4_cmd_ready", cmd_ready, 1'b0);
        rsp_ready = 1'b1;
        tick(1);
        rsp_ready = 1'b0;
        tick(19);
        chk("t4_still_blocked", cmd_ready, 1'b0);
        ack = 1'b0;
        tick(SYNC + 1);
        chk("t4_idle", busy, 1'b0);
        chk("t4_cmd_ready_back", cmd_ready, 1'b1);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;

        // 5: async reset while in REQ_HI
        issue(32'h3333_0005);
        wait_sig(0, 1'b1, 10, "t5_wait_req");
        tick(2);
        #2 rst = 1'b1;
        #1;
        chk("t5_req_async", req, 1'b0);
        chk("t5_data_out", data_out, 32'h0);
        chk("t5_busy", busy, 1'b0);
        tick(1);
        rst = 1'b0;
        do_txn(32'h3333_0055, 32'h5555_AAAA, 3);

        // 6: back-to-back random transactions
        mon_en = 1'b1;
        for (int i = 0; i < 100; i++) begin
            do_txn($urandom, $urandom, $urandom_range(1, 10));
        end
        mon_en = 1'b0;
        tick(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1);
    end

endmodule

`default_nettype wire
